// File: rtl/decoder_param_reg_if.sv
// rtl/decoder_param_reg_if.sv - code-in / vector-out handshake bundle for decoder_param_reg
interface decoder_param_reg_if #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_code;
   logic [1:0]        in_mode;
   logic              in_en;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_vec;
   logic              out_err;
   logic [7:0]        err_cnt;

   // upstream/downstream side (drives codes, consumes vectors)
   modport master (
      output in_valid, in_code, in_mode, in_en, out_ready,
      input  in_ready, out_valid, out_vec, out_err, err_cnt
   );

   // decoder side
   modport slave (
      input  in_valid, in_code, in_mode, in_en, out_ready,
      output in_ready, out_valid, out_vec, out_err, err_cnt
   );
endinterface

// File: rtl/decoder_param_reg.sv
// rtl/decoder_param_reg.sv - registered one-hot/thermometer/inverted decoder with error count
module decoder_param_reg #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   decoder_param_reg_if.slave    bus
);
   localparam logic [OUT_W-1:0] LP_ONE   = {{(OUT_W-1){1'b0}}, 1'b1};
   // OUT_W <= 2**IN_W, so one extra bit always holds the limit
   localparam logic [IN_W:0]    LP_LIMIT = (IN_W+1)'(OUT_W);

   logic              r_valid;
   logic [OUT_W-1:0]  r_vec;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic              w_accept;
   logic              w_oor;
   logic              w_sel;
   logic              w_err;
   logic [OUT_W-1:0]  w_onehot;
   logic [OUT_W-1:0]  w_thermo;
   logic [OUT_W-1:0]  w_vec;

   assign bus.in_ready  = rst_n && (!r_valid || bus.out_ready);
   assign w_accept      = bus.in_valid && bus.in_ready;
   assign w_onehot      = LP_ONE << bus.in_code;
   // bits 0..code set; code = OUT_W-1 wraps the shift to zero and yields all ones
   assign w_thermo      = (w_onehot << 1) - LP_ONE;
   assign w_oor         = {1'b0, bus.in_code} >= LP_LIMIT;
   assign w_sel         = bus.in_en && !w_oor;

   assign bus.out_valid = r_valid;
   assign bus.out_vec   = r_vec;
   assign bus.out_err   = r_err;
   assign bus.err_cnt   = r_cnt;

   // decode the offered beat; disabled or out-of-range beats give the mode's idle pattern
   always_comb begin
      w_vec = '0;
      w_err = 1'b0;
      case (bus.in_mode)
         2'b00: begin
            w_vec = w_sel ? w_onehot : '0;
            w_err = bus.in_en && w_oor;
         end
         2'b01: begin
            w_vec = w_sel ? w_thermo : '0;
            w_err = bus.in_en && w_oor;
         end
         2'b10: begin
            w_vec = w_sel ? ~w_onehot : '1;
            w_err = bus.in_en && w_oor;
         end
         default: begin
            w_vec = '0;
            w_err = 1'b1;
         end
      endcase
   end

   // output register: load on accept (replacing any drained beat), clear on drain, count errors
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_vec   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= 8'd0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_vec   <= w_vec;
         r_err   <= w_err;
         if (w_err && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end else if (r_valid && bus.out_ready) begin
         r_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decoder_param_reg.sv
// tb/tb_decoder_param_reg.sv - self-checking bench for decoder_param_reg (OUT_W 32 and 20)
module tb_decoder_param_reg;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [4:0] in_code;
   logic [1:0] in_mode;
   logic       in_en;
   logic       out_ready;
   logic       chk_on = 1'b0;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   decoder_param_reg_if #(.IN_W(5), .OUT_W(32)) ifa ();
   decoder_param_reg_if #(.IN_W(5), .OUT_W(20)) ifb ();

   assign ifa.in_valid  = in_valid;
   assign ifa.in_code   = in_code;
   assign ifa.in_mode   = in_mode;
   assign ifa.in_en     = in_en;
   assign ifa.out_ready = out_ready;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_code   = in_code;
   assign ifb.in_mode   = in_mode;
   assign ifb.in_en     = in_en;
   assign ifb.out_ready = out_ready;

   decoder_param_reg #(.IN_W(5), .OUT_W(32)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   decoder_param_reg #(.IN_W(5), .OUT_W(20)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   // model: vector bit k selected by comparing k with the code, per mode
   function automatic logic [31:0] f_vec(input logic [1:0] m, input logic en, input int code, input int w);
      logic [31:0] v;
      logic        sel;
      v = 32'd0;
      if (m == 2'b11) return 32'd0;
      for (int k = 0; k < w; k++) begin
         sel  = en && (code < w) && ((m == 2'b01) ? (k <= code) : (k == code));
         v[k] = (m == 2'b10) ? !sel : sel;
      end
      return v;
   endfunction

   function automatic logic f_err(input logic [1:0] m, input logic en, input int code, input int w);
      return (m == 2'b11) || (en && code >= w);
   endfunction

   int              w_of[2] = '{32, 20};
   logic [1:0]      m_valid;
   logic [1:0][31:0] m_vec;
   logic [1:0]      m_err;
   logic [1:0][7:0] m_cnt;

   // reference behaviour: register loaded on accept, held while stalled, count saturates
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_valid[i] <= 1'b0;
            m_vec[i]   <= 32'd0;
            m_err[i]   <= 1'b0;
            m_cnt[i]   <= 8'd0;
         end else if (in_valid && (!m_valid[i] || out_ready)) begin
            m_valid[i] <= 1'b1;
            m_vec[i]   <= f_vec(in_mode, in_en, int'(in_code), w_of[i]);
            m_err[i]   <= f_err(in_mode, in_en, int'(in_code), w_of[i]);
            if (f_err(in_mode, in_en, int'(in_code), w_of[i]) && m_cnt[i] != 8'hFF)
               m_cnt[i] <= m_cnt[i] + 8'd1;
         end else if (m_valid[i] && out_ready) begin
            m_valid[i] <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   logic [1:0][31:0] d_vec;
   logic [1:0]       d_valid, d_err, d_rdy;
   logic [1:0][7:0]  d_cnt;
   assign d_vec[0] = ifa.out_vec;
   assign d_vec[1] = {12'd0, ifb.out_vec};
   assign d_valid  = {ifb.out_valid, ifa.out_valid};
   assign d_err    = {ifb.out_err, ifa.out_err};
   assign d_rdy    = {ifb.in_ready, ifa.in_ready};
   assign d_cnt[0] = ifa.err_cnt;
   assign d_cnt[1] = ifb.err_cnt;

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), 32'(d_rdy[i]), 32'(rst_n && (!m_valid[i] || out_ready)));
            chk($sformatf("out_valid[%0d]", i), 32'(d_valid[i]), 32'(m_valid[i]));
            chk($sformatf("err_cnt[%0d]", i), 32'(d_cnt[i]), 32'(m_cnt[i]));
            if (m_valid[i]) begin
               chk($sformatf("out_vec[%0d]", i), d_vec[i], m_vec[i]);
               chk($sformatf("out_err[%0d]", i), 32'(d_err[i]), 32'(m_err[i]));
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] m, input logic en, input logic [4:0] c);
      in_valid = 1'b1;
      in_mode  = m;
      in_en    = en;
      in_code  = c;
      cyc();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_code = 5'd0; in_mode = 2'b00; in_en = 1'b0; out_ready = 1'b1;
      cyc();
      chk_on = 1'b1;
      cyc();
      chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
      chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_err_cnt", 32'(ifb.err_cnt), 32'd0);

      rst_n = 1'b1;
      beat(2'b00, 1'b1, 5'd5);
      chk("onehot5_vec", ifa.out_vec, 32'h0000_0020);
      chk("onehot5_err", 32'(ifa.out_err), 32'd0);
      chk("onehot5_valid", 32'(ifa.out_valid), 32'd1);
      beat(2'b01, 1'b1, 5'd3);
      chk("thermo3_vec", ifa.out_vec, 32'h0000_000F);
      chk("thermo3_vec_b", 32'(ifb.out_vec), 32'h0000_000F);
      beat(2'b10, 1'b1, 5'd0);
      chk("inv0_vec", ifa.out_vec, 32'hFFFF_FFFE);
      chk("inv0_vec_b", 32'(ifb.out_vec), 32'h000F_FFFE);
      beat(2'b01, 1'b1, 5'd19);
      chk("thermo19_vec_b", 32'(ifb.out_vec), 32'h000F_FFFF);
      beat(2'b01, 1'b1, 5'd31);
      chk("thermo31_vec", ifa.out_vec, 32'hFFFF_FFFF);
      in_valid = 1'b0;
      cyc();
      chk("drain_valid", 32'(ifa.out_valid), 32'd0);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;

      out_ready = 1'b0;
      beat(2'b00, 1'b1, 5'd1);
      chk("stall_in_ready", 32'(ifa.in_ready), 32'd0);
      chk("stall_vec1", ifa.out_vec, 32'h0000_0002);
      beat(2'b00, 1'b1, 5'd2);
      chk("stall_hold", ifa.out_vec, 32'h0000_0002);
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(ifa.in_ready), 32'd1);
      cyc();
      chk("no_bubble_vec", ifa.out_vec, 32'h0000_0004);
      chk("no_bubble_valid", 32'(ifa.out_valid), 32'd1);
      in_valid = 1'b0;
      cyc();

      beat(2'b00, 1'b1, 5'd25);
      chk("oor_err_b", 32'(ifb.out_err), 32'd1);
      chk("oor_vec_b", 32'(ifb.out_vec), 32'd0);
      chk("oor_cnt_b", 32'(ifb.err_cnt), 32'd1);
      chk("inrange25_vec_a", ifa.out_vec, 32'h0200_0000);
      chk("inrange25_cnt_a", 32'(ifa.err_cnt), 32'd0);
      beat(2'b10, 1'b1, 5'd20);
      chk("oor_inv_vec_b", 32'(ifb.out_vec), 32'h000F_FFFF);
      chk("oor_inv_cnt_b", 32'(ifb.err_cnt), 32'd2);
      for (int n = 0; n < 300; n++) beat(2'b11, 1'b1, 5'(n));
      chk("sat_cnt_a", 32'(ifa.err_cnt), 32'd255);
      chk("sat_cnt_b", 32'(ifb.err_cnt), 32'd255);
      chk("rsv_err_a", 32'(ifa.out_err), 32'd1);
      chk("rsv_vec_a", ifa.out_vec, 32'd0);

      beat(2'b10, 1'b0, 5'd7);
      chk("dis_inv_vec", ifa.out_vec, 32'hFFFF_FFFF);
      chk("dis_inv_err", 32'(ifa.out_err), 32'd0);
      chk("dis_inv_cnt", 32'(ifa.err_cnt), 32'd255);
      beat(2'b00, 1'b0, 5'd25);
      chk("dis_oor_err_b", 32'(ifb.out_err), 32'd0);
      chk("dis_oor_vec_b", 32'(ifb.out_vec), 32'd0);

      out_ready = 1'b0;
      beat(2'b00, 1'b1, 5'd4);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", 32'(ifa.in_ready), 32'd0);
      cyc();
      chk("rst_mid_valid", 32'(ifa.out_valid), 32'd0);
      chk("rst_mid_vec", ifa.out_vec, 32'd0);
      chk("rst_mid_cnt", 32'(ifa.err_cnt), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_vec", ifa.out_vec, 32'h0000_0010);
      chk("post_rst_valid", 32'(ifa.out_valid), 32'd1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      cyc();
      cyc();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/decoder_param_reg.md
DECODER_PARAM_REG -- requirements
Module: decoder_param_reg

Interface
REQ-001 The block SHALL have parameter IN_W, default 5, giving the code input width in bits.
REQ-002 The block SHALL have parameter OUT_W, default 32, giving the decoded output width; legal range 2 <= OUT_W <= 2**IN_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream code beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-007 The block SHALL have port in_code, input, IN_W bits: the code to decode.
REQ-008 The block SHALL have port in_mode, input, 2 bits: 00 one-hot, 01 thermometer, 10 inverted one-hot (active-low), 11 reserved.
REQ-009 The block SHALL have port in_en, input, 1 bit: the decode enable; 0 gives a no-select beat.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the output register holds an unconsumed beat.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output beat.
REQ-012 The block SHALL have port out_vec, output, OUT_W bits: the registered decoded vector.
REQ-013 The block SHALL have port out_err, output, 1 bit: the registered beat was out-of-range or used a reserved mode.
REQ-014 The block SHALL have port err_cnt, output, 8 bits: a saturating count of accepted error beats.

Function
REQ-015 in_ready SHALL equal (!out_valid || out_ready) combinationally, and SHALL be 0 while rst_n=0.
REQ-016 A beat SHALL be accepted on any rising edge where in_valid && in_ready && rst_n=1; out_vec/out_err SHALL be loaded on that edge (latency 1 cycle) and out_valid SHALL be set.
REQ-017 out_valid SHALL clear on an edge where out_valid && out_ready and no new beat is accepted.
REQ-018 On simultaneous drain and accept, the new beat SHALL replace the old one on the same edge, out_valid SHALL stay 1, and there SHALL be no bubble.
REQ-019 While out_valid && !out_ready, out_vec, out_err and out_valid SHALL hold stable.
REQ-020 Mode 00 SHALL produce out_vec bit k = 1 iff k == in_code.
REQ-021 Mode 01 SHALL produce out_vec bit k = 1 iff k <= in_code.
REQ-022 Mode 10 SHALL produce the bitwise inverse of mode 00.
REQ-023 When in_en=0 in a legal mode, out_vec SHALL be all-deasserted (all 0 for modes 00/01, all 1 for mode 10) and out_err SHALL be 0, regardless of in_code.
REQ-024 An error beat SHALL be one with (in_en=1 and in_code >= OUT_W) or in_mode=11.
REQ-025 An error beat SHALL produce out_err=1 and out_vec all 0 (mode 11), or the mode's all-deasserted value (out-of-range case).
REQ-026 err_cnt SHALL increment by 1 on each accepted error beat, saturate at 255, and never wrap.
REQ-027 Non-accepted input cycles SHALL not affect any state.

Reset
REQ-028 While rst_n=0 at a rising edge, out_valid SHALL go to 0, out_vec to all 0, out_err to 0, and err_cnt to 0.
REQ-029 Reset mid-transfer SHALL discard any held beat; no beat SHALL be accepted on a reset edge.
REQ-030 The first beat after reset SHALL be acceptable on the first edge with rst_n=1.

Verification
REQ-031 The bench SHALL cover: defaults, mode 00, in_code=5, in_en=1, out_ready=1 -> next cycle out_vec=0x00000020, out_err=0, out_valid=1.
REQ-032 The bench SHALL cover: mode 01, in_code=3 -> out_vec=0x0000000F; mode 10, in_code=0 -> out_vec=0xFFFFFFFE.
REQ-033 The bench SHALL cover: out_ready=0, then two beats offered (codes 1 and 2) -> in_ready=0 after the first, out_vec holds 0x00000002 (code 1); raising out_ready -> the code-2 beat loads the next edge with no gap.
REQ-034 The bench SHALL cover: IN_W=5, OUT_W=20, code 25, mode 00 -> out_err=1, out_vec=0, err_cnt=1; then 300 mode-11 beats -> err_cnt=255 and held there.
REQ-035 The bench SHALL cover: in_en=0, mode 10, code 7 -> out_vec=0xFFFFFFFF, out_err=0, err_cnt unchanged.
REQ-036 The bench SHALL cover: rst_n=0 for one edge while out_valid=1 and out_ready=0 -> out_valid=0, out_vec=0, err_cnt=0, and in_ready=0 during reset.
